mac_seq_ctrl: RTL and testbench
===============================

# mac_seq_ctrl

Sequencing controller for one shared combinational MAC datapath (`in_a*in_b+in_c`, INT8/FP16 modes, overflow/underflow error flag). It accepts a job (mode, vector length, bias), streams operand pairs through the MAC with valid/ready handshaking, and feeds the accumulator back into the adder input. It returns one dot-product result plus a sticky error flag. It sits between the systolic-array operand feeders and a single MAC instance. The MAC is instantiated outside this block and connected through the `mac_*` ports.

## Interface
- `LEN_W`, 8, width of the job length field; maximum vector length is 2^LEN_W-1.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: job request; accepted only in IDLE.
- `cfg_mode` in 1: 0 = INT8, 1 = FP16; latched when start is accepted.
- `cfg_len` in LEN_W: number of operand pairs; latched when start is accepted.
- `cfg_bias` in 16: initial accumulator value; latched when start is accepted.
- `busy` out 1: high in RUN and DONE.
- `op_valid` in 1: operand pair valid.
- `op_ready` out 1: operand pair accepted; high only in RUN.
- `op_a`, `op_b` in 16: multiplier operands.
- `mac_a`, `mac_b` out 16: to MAC `in_a`/`in_b`.
- `mac_c` out 16: to MAC `in_c`; always equals `acc`.
- `mac_mode` out 1: to MAC `mode`; always equals `mode_q`.
- `mac_out` in 16: MAC result.
- `mac_error` in 1: MAC error flag.
- `res_valid` out 1: result valid.
- `res_ready` in 1: result consumed.
- `res_data` out 16: final accumulator value.
- `res_error` out 1: sticky error for the job.

## Operation
- States: IDLE, RUN, DONE. The state is encoded in 2 bits; the unused encoding recovers to IDLE.
- Registers:
  - `acc[15:0]`
  - `cnt[LEN_W-1:0]`, counting operand pairs remaining
  - `mode_q`
  - `err_q`
- IDLE:
  - On `start`: `acc <= cfg_bias`, `cnt <= cfg_len`, `mode_q <= cfg_mode`, `err_q <= 0`.
  - Next state is RUN if `cfg_len != 0`, otherwise DONE.
- RUN:
  - `op_ready = 1`. `mac_a = op_a`, `mac_b = op_b`.
  - On a beat (`op_valid & op_ready`): `acc <= mac_out`, `err_q <= err_q | mac_error`, `cnt <= cnt-1`.
  - The beat taken when `cnt == 1` moves to DONE.
  - No beat: all registers hold.
- DONE:
  - `res_valid = 1`, `res_data = acc`, `res_error = err_q`.
  - On `res_ready` the state moves to IDLE. `acc` and `err_q` keep their values until the next start.
- Outside RUN: `mac_a = mac_b = 0`, so the MAC sees 0*0+acc.
- `start` is ignored while `busy`. Sampling `cfg_*` only on an accepted start makes mid-job cfg changes harmless.
- Arithmetic is entirely inside the MAC. This block never modifies data bits.
- Reset, at any state including mid-job: the state goes to IDLE and the job is abandoned without a result.

## Timing
- Reset values: `busy = 0`, `op_ready = 0`, `res_valid = 0`, `res_data = 0`, `res_error = 0`, `mac_a = mac_b = mac_c = 0`, `mac_mode = 0`.
- `op_ready`, `res_valid` and `busy` decode from registered state only. There are no combinational paths from `op_valid` or `res_ready` to the outputs.
- The MAC path is combinational from `op_a`/`op_b`/`acc` to `mac_out`. `acc` is updated at the clock edge of the beat.
- Latency:
  - Start accepted at edge T: RUN from T+1.
  - With `op_valid` held high, the last beat is at T+len and `res_valid` rises at T+len+1.
  - `len = 0`: `res_valid` rises at T+1 with `res_data = cfg_bias`.
- Throughput: one operand pair per cycle. Back-to-back jobs are separated by at least one IDLE cycle after the `res_ready` handshake.
- `op_valid` gaps stall RUN without limit. `res_ready` low holds DONE and the result stable.

## Configuration
- `MAC_SEQ_ERR_STOP_EN` defined:
  - A RUN beat with `mac_error = 1` sets `err_q` and goes directly to DONE, regardless of `cnt`.
  - `acc` takes the erroring `mac_out`.
  - The remaining operands are not consumed. The upstream feeder must flush them.
- `MAC_SEQ_ERR_STOP_EN` undefined:
  - The error is only accumulated into `err_q`, and the job always consumes exactly `cfg_len` pairs.

## Test plan
- FP16 dot product: mode=1, len=2, bias=0x3C00, pairs (0x3C00,0x4000) and (0x4000,0x4000), `op_valid` held high -> `res_valid` at start+3, `res_data` = 0x4700 (7.0), `res_error` = 0.
- Zero length: len=0, bias=0x1234 -> `res_valid` the cycle after start, `res_data` = 0x1234, `op_ready` never high.
- Back-pressure:
  - Stimulus: len=3; `op_valid` toggles 1,0,1,0,1; `res_ready` held low 4 cycles.
  - Required: exactly 3 beats consumed, `res_data` matches the golden MAC model, and the result stays stable until `res_ready` is asserted.
- Overflow: mode=1, len=2, first pair (0x7BFF,0x7BFF):
  - Macro off: 2 beats consumed, `res_error` = 1.
  - Macro on: DONE after 1 beat, second pair not accepted.
- Disturbances:
  - `start` pulsed during RUN with different cfg: ignored.
  - `rst_n` low mid-RUN: next cycle `busy` = 0, `op_ready` = 0, and no `res_valid` is produced.
- INT8 regression: mode=0, len=4, random signed operands -> `res_data` bit-exact against the golden MAC model chained 4 times from bias.

Source files
------------

// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if: bundle of every non-clock signal of mac_seq_ctrl.
//
// Handshakes (valid/ready): a transfer happens on a rising clk edge where
// both valid and ready are high. The producer holds valid and its payload
// stable until that transfer, and ready never depends combinationally on valid.
// Channels: job request (start + cfg_*, taken only while idle), operand
// pairs (op_valid/op_ready + op_a/op_b), result (res_valid/res_ready +
// res_data/res_error).
//
// Groups:
//   job      : start, cfg_mode, cfg_len[LEN_W], cfg_bias[16], busy
//   operands : op_valid, op_ready, op_a[16], op_b[16]
//   mac port : mac_a/mac_b/mac_c[16], mac_mode out; mac_out[16], mac_error in
//   result   : res_valid, res_ready, res_data[16], res_error
//   debug    : state_dbg[2] (controller FSM state)
// Modports: slave = the controller, master = its environment.
interface mac_seq_ctrl_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic             cfg_mode;
    logic [LEN_W-1:0] cfg_len;
    logic [15:0]      cfg_bias;
    logic             busy;

    logic             op_valid;
    logic             op_ready;
    logic [15:0]      op_a;
    logic [15:0]      op_b;

    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic [15:0]      mac_c;
    logic             mac_mode;
    logic [15:0]      mac_out;
    logic             mac_error;

    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic             res_error;

    logic [1:0]       state_dbg;

    modport slave (
        input  start, cfg_mode, cfg_len, cfg_bias,
        input  op_valid, op_a, op_b,
        input  mac_out, mac_error,
        input  res_ready,
        output busy, op_ready,
        output mac_a, mac_b, mac_c, mac_mode,
        output res_valid, res_data, res_error,
        output state_dbg
    );

    modport master (
        output start, cfg_mode, cfg_len, cfg_bias,
        output op_valid, op_a, op_b,
        output mac_out, mac_error,
        output res_ready,
        input  busy, op_ready,
        input  mac_a, mac_b, mac_c, mac_mode,
        input  res_valid, res_data, res_error,
        input  state_dbg
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one dot-product job through an external
// combinational MAC (mac_out = mac_a*mac_b + mac_c). The accumulator is fed
// back into mac_c; each accepted operand pair replaces it with mac_out.
// The MAC error flag is collected into a sticky per-job error.
//
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset (abandons any job, no result)
//   bus   : mac_seq_ctrl_if.slave (job, operand, MAC, result, debug groups)
//
// Build option: define MAC_SEQ_ERR_STOP_EN to end a job at the first beat
// whose MAC result flags an error (remaining operands are left unconsumed).
// Without it, every job consumes exactly cfg_len pairs.
module mac_seq_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mac_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             err_q, err_d;

    // Handshake flags are registered copies of the next-state decode, so
    // they depend only on flops and never on op_valid/res_ready directly.
    logic             busy_q, busy_d;
    logic             op_ready_q, op_ready_d;
    logic             res_valid_q, res_valid_d;

    logic             beat;
    logic             last_beat;

    assign beat = bus.op_valid & op_ready_q;

`ifdef MAC_SEQ_ERR_STOP_EN
    assign last_beat = beat & ((cnt_q == LEN_W'(1)) | bus.mac_error);
`else
    assign last_beat = beat & (cnt_q == LEN_W'(1));
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.cfg_bias;
                    cnt_d   = bus.cfg_len;
                    mode_d  = bus.cfg_mode;
                    err_d   = 1'b0;
                    // A zero-length job returns the bias straight away.
                    state_d = (bus.cfg_len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (beat) begin
                    acc_d = bus.mac_out;
                    err_d = err_q | bus.mac_error;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // acc/err stay put after the handshake until the next start.
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d == ST_RUN) || (state_d == ST_DONE);
        op_ready_d  = (state_d == ST_RUN);
        res_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Outside RUN the multiplier inputs are forced to zero so the MAC just
    // passes the accumulator through (0*0 + acc).
    assign bus.mac_a     = op_ready_q ? bus.op_a : 16'd0;
    assign bus.mac_b     = op_ready_q ? bus.op_b : 16'd0;
    assign bus.mac_c     = acc_q;
    assign bus.mac_mode  = mode_q;

    assign bus.busy      = busy_q;
    assign bus.op_ready  = op_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_valid_q ? acc_q : 16'd0;
    assign bus.res_error = res_valid_q & err_q;

    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: bench for mac_seq_ctrl. Provides a behavioural MAC
// (INT8 and FP16 a*b+c with overflow/underflow flag) on the mac_* ports and
// checks every job against a dot-product model folded over the operand list.
module tb_mac_seq_ctrl;
    localparam int LEN_W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mac_seq_ctrl_if #(.LEN_W(LEN_W)) bus ();

    mac_seq_ctrl #(.LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- golden MAC ----------------
    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) begin
            for (int i = 0; i < n; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -n; i++) r = r / 2.0;
        end
        return r;
    endfunction

    function automatic real fp16_to_real(input logic [15:0] h);
        real v;
        int  e;
        e = int'(h[14:10]);
        if (e == 31) v = 1.0e30;
        else if (e == 0) v = real'(h[9:0]) / 16777216.0;
        else v = (1.0 + real'(h[9:0]) / 1024.0) * pow2(e - 15);
        if (h[15]) v = -v;
        return v;
    endfunction

    // Returns {error, fp16 bits}; error on overflow or on a nonzero result
    // that lands in the subnormal/zero range.
    function automatic logic [16:0] real_to_fp16(input real v);
        real  m;
        int   e;
        int   mant;
        logic s;
        s = (v < 0.0);
        m = s ? -v : v;
        if (m == 0.0) return {1'b0, s, 15'd0};
        if (m >= 65520.0) return {1'b1, s, 5'h1F, 10'd0};
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0 && e > -14) begin m = m * 2.0; e--; end
        if (m < 1.0) begin
            mant = $rtoi(m * 1024.0 + 0.5);
            if (mant == 1024) return {1'b0, s, 5'd1, 10'd0};
            return {1'b1, s, 5'd0, mant[9:0]};
        end
        mant = $rtoi((m - 1.0) * 1024.0 + 0.5);
        if (mant == 1024) begin mant = 0; e++; end
        if (e > 15) return {1'b1, s, 5'h1F, 10'd0};
        return {1'b0, s, 5'(e + 15), mant[9:0]};
    endfunction

    function automatic logic [16:0] mac_model(input logic mode, input logic [15:0] a,
                                              input logic [15:0] b, input logic [15:0] c);
        int p;
        if (mode) begin
            return real_to_fp16(fp16_to_real(a) * fp16_to_real(b) + fp16_to_real(c));
        end
        p = int'($signed(a[7:0])) * int'($signed(b[7:0])) + int'($signed(c));
        return {(p > 32767) || (p < -32768), p[15:0]};
    endfunction

    logic [16:0] mac_res;
    always_comb mac_res = mac_model(bus.mac_mode, bus.mac_a, bus.mac_b, bus.mac_c);
    assign bus.mac_out   = mac_res[15:0];
    assign bus.mac_error = mac_res[16];

    // ---------------- reference model / scoreboard ----------------
    logic [15:0] pa [256];
    logic [15:0] pb [256];
    logic [16:0] exp_q [$];
    logic [15:0] last_data;
    logic        last_err;
    int          last_beats;

    // Dot product folded over the operand list, starting from the bias.
    function automatic void model_job(input logic mode, input int len, input logic [15:0] bias,
                                      output logic [15:0] acc, output logic err, output int n);
        logic [16:0] r;
        acc = bias;
        err = 1'b0;
        n   = 0;
        for (int i = 0; i < len; i++) begin
            r   = mac_model(mode, pa[i], pb[i], acc);
            acc = r[15:0];
            err = err | r[16];
            n++;
`ifdef MAC_SEQ_ERR_STOP_EN
            if (r[16]) break;
`endif
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_pairs(input logic mode, input int len);
        for (int i = 0; i < len; i++) begin
            if (mode) begin
                pa[i] = {1'($urandom), 5'($urandom_range(10, 18)), 10'($urandom)};
                pb[i] = {1'($urandom), 5'($urandom_range(10, 18)), 10'($urandom)};
            end else begin
                pa[i] = 16'($urandom);
                pb[i] = 16'($urandom);
            end
        end
    endtask

    // ---------------- driver ----------------
    // gap: 0 = op_valid held high, 1 = toggling 1,0,1,..., 2 = random.
    task automatic run_job(input logic mode, input int len, input logic [15:0] bias,
                           input int gap, input int rr_delay, input bit disturb);
        logic [15:0] e_acc;
        logic        e_err;
        int          e_n;
        logic [16:0] exp_res;
        int          cyc;
        int          beats;
        int          budget;
        logic        rdy;
        logic        vld;

        model_job(mode, len, bias, e_acc, e_err, e_n);
        exp_q.push_back({e_err, e_acc});

        check("idle_before_start", 32'(bus.busy), 0);
        bus.cfg_mode = mode;
        bus.cfg_len  = LEN_W'(len);
        bus.cfg_bias = bias;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.cfg_mode = ~mode;
        bus.cfg_len  = LEN_W'($urandom_range(1, 255));
        bus.cfg_bias = 16'($urandom);

        check("busy_after_start", 32'(bus.busy), 1);
        if (len == 0) begin
            check("zero_len_no_op_ready", 32'(bus.op_ready), 0);
        end else begin
            check("run_mac_c_is_bias", 32'(bus.mac_c), 32'(bias));
            check("run_mac_mode", 32'(bus.mac_mode), 32'(mode));
        end

        cyc    = 0;
        beats  = 0;
        budget = 4 * len + 20;
        while (!bus.res_valid && cyc < budget) begin
            bus.start = (disturb && cyc == 0);
            case (gap)
                0:       vld = 1'b1;
                1:       vld = (cyc % 2 == 0);
                default: vld = 1'($urandom_range(0, 1));
            endcase
            bus.op_valid = vld;
            bus.op_a     = pa[beats & 255];
            bus.op_b     = pb[beats & 255];
            rdy          = bus.op_ready;
            #1;
            if (rdy && beats == 0) begin
                check("run_mac_a_passthru", 32'(bus.mac_a), 32'(pa[0]));
                check("run_mac_b_passthru", 32'(bus.mac_b), 32'(pb[0]));
            end
            @(posedge clk); #1;
            if (vld && rdy) beats++;
            cyc++;
        end
        bus.start    = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_a     = 16'hA5A5;
        bus.op_b     = 16'h5A5A;

        exp_res = exp_q.pop_front();
        check("res_valid_rises", 32'(bus.res_valid), 1);
        check("beats_consumed", beats, e_n);
        check("res_data", 32'(bus.res_data), 32'(exp_res[15:0]));
        check("res_error", 32'(bus.res_error), 32'(exp_res[16]));
        if (gap == 0) check("latency", cyc, e_n);
        #1;
        check("done_op_ready_low", 32'(bus.op_ready), 0);
        check("done_mac_a_zero", 32'(bus.mac_a), 0);
        check("done_mac_c_is_acc", 32'(bus.mac_c), 32'(exp_res[15:0]));
        last_data  = bus.res_data;
        last_err   = bus.res_error;
        last_beats = beats;

        for (int i = 0; i < rr_delay; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(bus.res_valid), 1);
            check("hold_data", 32'(bus.res_data), 32'(exp_res[15:0]));
            check("hold_error", 32'(bus.res_error), 32'(exp_res[16]));
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        check("released_valid", 32'(bus.res_valid), 0);
        check("released_busy", 32'(bus.busy), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   m;
        int   l;
        logic seen;

        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.cfg_mode  = 1'b1;
        bus.cfg_len   = 8'd7;
        bus.cfg_bias  = 16'hBEEF;
        bus.op_valid  = 1'b1;
        bus.op_a      = 16'h1357;
        bus.op_b      = 16'h2468;
        bus.res_ready = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_op_ready", 32'(bus.op_ready), 0);
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_res_data", 32'(bus.res_data), 0);
        check("rst_res_error", 32'(bus.res_error), 0);
        check("rst_mac_a", 32'(bus.mac_a), 0);
        check("rst_mac_b", 32'(bus.mac_b), 0);
        check("rst_mac_c", 32'(bus.mac_c), 0);
        check("rst_mac_mode", 32'(bus.mac_mode), 0);
        bus.op_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // FP16 dot product: 1*2 + 1 = 3, then 2*2 + 3 = 7
        pa[0] = 16'h3C00; pb[0] = 16'h4000;
        pa[1] = 16'h4000; pb[1] = 16'h4000;
        run_job(1'b1, 2, 16'h3C00, 0, 0, 1'b0);
        check("fp16_result_7", 32'(last_data), 32'h4700);
        check("fp16_no_error", 32'(last_err), 0);

        // zero length returns the bias
        run_job(1'b0, 0, 16'h1234, 0, 0, 1'b0);
        check("zero_len_bias", 32'(last_data), 32'h1234);

        // back-pressure on both sides
        fill_pairs(1'b0, 3);
        run_job(1'b0, 3, 16'($urandom), 1, 4, 1'b0);
        check("backpressure_beats", last_beats, 3);

        // FP16 overflow on the first pair
        pa[0] = 16'h7BFF; pb[0] = 16'h7BFF;
        pa[1] = 16'h3C00; pb[1] = 16'h3C00;
        run_job(1'b1, 2, 16'h0000, 0, 1, 1'b0);
        check("overflow_error", 32'(last_err), 1);
`ifdef MAC_SEQ_ERR_STOP_EN
        check("overflow_beats_stop", last_beats, 1);
`else
        check("overflow_beats_full", last_beats, 2);
`endif

        // start pulsed mid-job with other cfg is ignored
        fill_pairs(1'b0, 4);
        run_job(1'b0, 4, 16'($urandom), 0, 0, 1'b1);

        // reset in the middle of RUN abandons the job
        fill_pairs(1'b0, 5);
        bus.cfg_mode = 1'b0;
        bus.cfg_len  = 8'd5;
        bus.cfg_bias = 16'h0042;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.op_valid = 1'b1;
        bus.op_a     = pa[0];
        bus.op_b     = pb[0];
        repeat (2) begin @(posedge clk); #1; end
        check("mid_run_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_op_ready", 32'(bus.op_ready), 0);
        check("midrst_res_valid", 32'(bus.res_valid), 0);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.res_valid || bus.busy) seen = 1'b1;
        end
        check("midrst_no_result", 32'(seen), 0);
        bus.op_valid = 1'b0;

        // INT8 regression, length 4, random signed operands
        for (int j = 0; j < 5; j++) begin
            fill_pairs(1'b0, 4);
            run_job(1'b0, 4, 16'($urandom), 0, $urandom_range(0, 2), 1'b0);
        end

        // maximum length
        fill_pairs(1'b0, 255);
        run_job(1'b0, 255, 16'($urandom), 0, 0, 1'b0);
        check("max_len_beats", last_beats, 255);

        // random jobs, both modes, random gaps and result back-pressure
        for (int j = 0; j < 12; j++) begin
            m = $urandom_range(0, 1);
            l = $urandom_range(0, 8);
            fill_pairs(1'(m), l);
            run_job(1'(m), l, 16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
